// File: rtl/sha2_sigma_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sha2_sigma_unit: SHA-256/SHA-512 sigma/sum evaluator, valid/ready output    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module sha2_sigma_unit #(
  parameter int XLEN = 32,
  parameter int PIPE = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      opcode,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rd,
  output logic            out_last
);

  localparam logic [1:0] C_SIG0 = 2'd0;
  localparam logic [1:0] C_SIG1 = 2'd1;
  localparam logic [1:0] C_SUM0 = 2'd2;
  localparam logic [1:0] C_SUM1 = 2'd3;
  localparam bit TWO_BEAT = (XLEN == 32);

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_FULL_LO = 2'd1,
    S_FULL_HI = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [63:0] r_res;
  logic        r_two;

  logic [31:0] w_x32, w_s256;
  logic [63:0] w_x64, w_s512, w_res;
  logic        w_two, w_accept, w_block, w_out_free, w_load;
  logic        w_src_valid, w_src_two;
  logic [63:0] w_src_res;

  function automatic logic [31:0] ror32(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // With a 32-bit datapath the SHA-512 operand is split across both sources.
  if (XLEN == 64) begin : g_op64
    assign w_x64 = rs1;
  end else begin : g_op32
    assign w_x64 = {rs2, rs1};
  end

  always_comb begin
    w_x32  = rs1[31:0];
    w_s256 = '0;
    w_s512 = '0;
    case (opcode[1:0])
      C_SIG0: begin
        w_s256 = ror32(w_x32, 7) ^ ror32(w_x32, 18) ^ (w_x32 >> 3);
        w_s512 = ror64(w_x64, 1) ^ ror64(w_x64, 8) ^ (w_x64 >> 7);
      end
      C_SIG1: begin
        w_s256 = ror32(w_x32, 17) ^ ror32(w_x32, 19) ^ (w_x32 >> 10);
        w_s512 = ror64(w_x64, 19) ^ ror64(w_x64, 61) ^ (w_x64 >> 6);
      end
      C_SUM0: begin
        w_s256 = ror32(w_x32, 2) ^ ror32(w_x32, 13) ^ ror32(w_x32, 22);
        w_s512 = ror64(w_x64, 28) ^ ror64(w_x64, 34) ^ ror64(w_x64, 39);
      end
      C_SUM1: begin
        w_s256 = ror32(w_x32, 6) ^ ror32(w_x32, 11) ^ ror32(w_x32, 25);
        w_s512 = ror64(w_x64, 14) ^ ror64(w_x64, 18) ^ ror64(w_x64, 41);
      end
      default: ;
    endcase
    w_res = opcode[2] ? w_s512 : {{32{w_s256[31]}}, w_s256};
    w_two = TWO_BEAT && opcode[2];
  end

  assign w_accept   = in_valid && in_ready;
  assign w_block    = (r_state == S_FULL_HI) || ((r_state == S_FULL_LO) && r_two);
  assign w_out_free = (r_state == S_EMPTY) ||
                      (out_ready && (((r_state == S_FULL_LO) && !r_two) || (r_state == S_FULL_HI)));
  assign w_load     = w_src_valid && w_out_free;

  if (PIPE == 1) begin : g_pipe
    logic        r_s1_valid;
    logic [63:0] r_s1_res;
    logic        r_s1_two;

    assign w_src_valid = r_s1_valid;
    assign w_src_res   = r_s1_res;
    assign w_src_two   = r_s1_two;
    assign in_ready    = !w_block && (!r_s1_valid || w_out_free);

    always_ff @(posedge clk) begin
      if (rst) begin
        r_s1_valid <= 1'b0;
        r_s1_res   <= '0;
        r_s1_two   <= 1'b0;
      end else if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_s1_res   <= w_res;
        r_s1_two   <= w_two;
      end else if (w_out_free) begin
        r_s1_valid <= 1'b0;
      end
    end
  end else begin : g_nopipe
    assign w_src_valid = w_accept;
    assign w_src_res   = w_res;
    assign w_src_two   = w_two;
    assign in_ready    = !w_block && ((r_state == S_EMPTY) || (out_valid && out_ready && out_last));
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY:   if (w_load) w_state_nxt = S_FULL_LO;
      S_FULL_LO: if (out_ready) begin
        if (r_two)       w_state_nxt = S_FULL_HI;
        else if (w_load) w_state_nxt = S_FULL_LO;
        else             w_state_nxt = S_EMPTY;
      end
      S_FULL_HI: if (out_ready) w_state_nxt = w_load ? S_FULL_LO : S_EMPTY;
      default:   w_state_nxt = S_EMPTY;
    endcase
  end

  // The whole 64-bit result is captured once; the high beat replays it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_res   <= '0;
      r_two   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_res <= w_src_res;
        r_two <= w_src_two;
      end
    end
  end

  assign out_valid = (r_state != S_EMPTY);
  assign out_last  = (r_state == S_FULL_HI) || ((r_state == S_FULL_LO) && !r_two);

  if (XLEN == 64) begin : g_rd64
    assign rd = r_res;
  end else begin : g_rd32
    assign rd = (r_state == S_FULL_HI) ? r_res[63:32] : r_res[31:0];
  end

endmodule
`default_nettype wire
